// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_pkg
//  Description : Shared types and address-field helpers for the direct-mapped
//                write-through data cache. Widths below describe the default
//                geometry (256 sets, 4 words/line, 32-bit byte addresses).
//  Revision    : 1.0  initial release
// ============================================================================
package dcache_pkg;

    localparam int c_ADDR_W   = 32;
    localparam int c_NUM_SETS = 256;
    localparam int c_WORDS    = 4;
    localparam int c_OFF_W    = $clog2(c_WORDS);
    localparam int c_IDX_W    = $clog2(c_NUM_SETS);
    localparam int c_TAG_W    = c_ADDR_W - c_IDX_W - c_OFF_W - 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_e;

    function automatic logic [c_TAG_W-1:0] tag_of(input logic [c_ADDR_W-1:0] addr);
        return addr[c_ADDR_W-1 -: c_TAG_W];
    endfunction

    function automatic logic [c_IDX_W-1:0] index_of(input logic [c_ADDR_W-1:0] addr);
        return addr[c_OFF_W+2 +: c_IDX_W];
    endfunction

    function automatic logic [c_OFF_W-1:0] word_of(input logic [c_ADDR_W-1:0] addr);
        return addr[2 +: c_OFF_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_array.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_array
//  Description : Data, tag and valid storage for the data cache.
//                Data/tag: synchronous write, combinational read, not reset.
//                Valid   : one bit per line, asynchronously cleared.
//  Ports       : clk, rst_n          clock / async active-low reset
//                i_index, i_word     line and word select
//                i_data_we, i_wdata  word write
//                i_tag_we, i_tag     tag write, also marks the line valid
//                o_rdata, o_tag, o_valid  combinational read of selected entry
//  Revision    : 1.0  initial release
// ============================================================================
module dcache_array #(
    parameter int NUM_SETS        = 256,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int DATA_W          = 32,
    parameter int TAG_W           = 20,
    parameter int IDX_W           = 8,
    parameter int OFF_W           = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  i_index,
    input  logic [OFF_W-1:0]  i_word,
    input  logic              i_data_we,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_tag_we,
    input  logic [TAG_W-1:0]  i_tag,
    output logic [DATA_W-1:0] o_rdata,
    output logic [TAG_W-1:0]  o_tag,
    output logic              o_valid
);

    logic [DATA_W-1:0] r_data [NUM_SETS][WORDS_PER_BLOCK];
    logic [TAG_W-1:0]  r_tag  [NUM_SETS];
    logic [NUM_SETS-1:0] r_valid;

    always_ff @(posedge clk) begin
        if (i_data_we) r_data[i_index][i_word] <= i_wdata;
        if (i_tag_we)  r_tag[i_index]          <= i_tag;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_valid          <= '0;
        else if (i_tag_we) r_valid[i_index] <= 1'b1;
    end

    assign o_rdata = r_data[i_index][i_word];
    assign o_tag   = r_tag[i_index];
    assign o_valid = r_valid[i_index];

endmodule
`default_nettype wire

// File: rtl/dcache_wt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_wt_ctrl
//  Description : Direct-mapped, write-through, no-write-allocate data cache
//                controller. Read hits return data in the same cycle; read
//                misses fill a whole line beat by beat; every store is
//                forwarded to memory and stalls the CPU until acknowledged.
//  Ports       : clk, reset (async, active-low)
//                cpu_re/cpu_we/cpu_addr/cpu_wdata  CPU request (held on stall)
//                cpu_rdata/cpu_stall               CPU response
//                mem_re/mem_we/mem_addr/mem_wdata  memory request
//                mem_rdata/mem_ready               memory response
//                hit_count/miss_count              read statistics
//  Revision    : 1.0  initial release
// ============================================================================
module dcache_wt_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_SETS        = 256,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_re,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    localparam int c_OFF_W = $clog2(WORDS_PER_BLOCK);
    localparam int c_IDX_W = $clog2(NUM_SETS);
    localparam int c_TAG_W = ADDR_W - c_IDX_W - c_OFF_W - 2;
    localparam int c_BLK_W = ADDR_W - c_OFF_W - 2;
    localparam logic [c_OFF_W-1:0] c_LAST_BEAT = c_OFF_W'(WORDS_PER_BLOCK - 1);

    state_e               r_state, w_next_state;
    logic [c_OFF_W-1:0]   r_beat;
    logic [31:0]          r_hit_count, r_miss_count;

    logic [c_TAG_W-1:0]   w_cpu_tag, w_line_tag;
    logic [c_IDX_W-1:0]   w_cpu_index;
    logic [c_OFF_W-1:0]   w_cpu_word, w_arr_word;
    logic [DATA_W-1:0]    w_arr_rdata, w_arr_wdata;
    logic                 w_line_valid, w_hit;
    logic                 w_data_we, w_tag_we;
    logic                 w_hit_inc, w_miss_inc, w_beat_inc, w_beat_clr;
    logic                 w_unused_addr;

    assign w_cpu_tag     = cpu_addr[ADDR_W-1 -: c_TAG_W];
    assign w_cpu_index   = cpu_addr[c_OFF_W+2 +: c_IDX_W];
    assign w_cpu_word    = cpu_addr[2 +: c_OFF_W];
    assign w_unused_addr = ^cpu_addr[1:0];
    assign w_hit         = w_line_valid && (w_line_tag == w_cpu_tag);

    // The CPU holds its address through a fill, so the fill indexes the
    // line from cpu_addr and only the word select comes from the beat count.
    dcache_array #(
        .NUM_SETS        (NUM_SETS),
        .WORDS_PER_BLOCK (WORDS_PER_BLOCK),
        .DATA_W          (DATA_W),
        .TAG_W           (c_TAG_W),
        .IDX_W           (c_IDX_W),
        .OFF_W           (c_OFF_W)
    ) u_array (
        .clk       (clk),
        .rst_n     (reset),
        .i_index   (w_cpu_index),
        .i_word    (w_arr_word),
        .i_data_we (w_data_we),
        .i_wdata   (w_arr_wdata),
        .i_tag_we  (w_tag_we),
        .i_tag     (w_cpu_tag),
        .o_rdata   (w_arr_rdata),
        .o_tag     (w_line_tag),
        .o_valid   (w_line_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_beat       <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_beat_clr)      r_beat <= '0;
            else if (w_beat_inc) r_beat <= r_beat + 1'b1;
            if (w_hit_inc)  r_hit_count  <= r_hit_count + 32'd1;
            if (w_miss_inc) r_miss_count <= r_miss_count + 32'd1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        cpu_stall    = 1'b0;
        cpu_rdata    = w_arr_rdata;
        mem_re       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = {cpu_addr[ADDR_W-1:2], 2'b00};
        mem_wdata    = cpu_wdata;
        w_arr_word   = w_cpu_word;
        w_arr_wdata  = cpu_wdata;
        w_data_we    = 1'b0;
        w_tag_we     = 1'b0;
        w_hit_inc    = 1'b0;
        w_miss_inc   = 1'b0;
        w_beat_inc   = 1'b0;
        w_beat_clr   = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (cpu_we) begin
                    // Write-through: refresh the cached copy only on a hit.
                    w_data_we    = w_hit;
                    cpu_stall    = 1'b1;
                    w_next_state = WRITE;
                end else if (cpu_re && w_hit) begin
                    w_hit_inc = 1'b1;
                end else if (cpu_re) begin
                    cpu_stall    = 1'b1;
                    w_miss_inc   = 1'b1;
                    w_beat_clr   = 1'b1;
                    w_next_state = FILL;
                end
            end
            FILL: begin
                mem_re    = 1'b1;
                mem_addr  = {cpu_addr[ADDR_W-1 -: c_BLK_W], r_beat, 2'b00};
                cpu_stall = 1'b1;
                if (mem_ready) begin
                    w_arr_word  = r_beat;
                    w_arr_wdata = mem_rdata;
                    w_data_we   = 1'b1;
                    if (r_beat == c_LAST_BEAT) begin
                        w_tag_we     = 1'b1;
                        w_beat_clr   = 1'b1;
                        w_next_state = IDLE;
                    end else begin
                        w_beat_inc = 1'b1;
                    end
                end
            end
            WRITE: begin
                mem_we    = 1'b1;
                // Release the CPU in the acknowledge cycle so the store retires.
                cpu_stall = !mem_ready;
                if (mem_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

endmodule
`default_nettype wire

// File: tb/tb_dcache_wt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dcache_wt_ctrl
//  Description : Directed self-checking bench for dcache_wt_ctrl. Inputs are
//                driven on the falling edge, outputs sampled 1 ns later.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dcache_wt_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_re, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall, mem_re, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] hit_count, miss_count;
    logic [31:0] fill_base;
    int          total  = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    // Memory returns fill_base + word offset for every beat.
    assign mem_rdata = fill_base + {30'd0, mem_addr[3:2]};

    dcache_wt_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_re     (cpu_re),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem_ready = 1'b0; fill_base = '0;

        // Reset state
        @(negedge clk); @(negedge clk); #1;
        chk1("rst_mem_re", mem_re, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk1("rst_stall", cpu_stall, 1'b0);
        chk("rst_hits", hit_count, 32'd0);
        chk("rst_misses", miss_count, 32'd0);
        @(negedge clk); reset = 1'b1;

        // Cold read miss at 0x40, fill A0..A3
        @(negedge clk); cpu_re = 1'b1; cpu_addr = 32'h40; mem_ready = 1'b1; fill_base = 32'hA0; #1;
        chk1("miss_stall", cpu_stall, 1'b1);
        chk1("miss_no_mem_re", mem_re, 1'b0);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk); #1;
            chk("fill1_addr", mem_addr, 32'h40 + 32'(4 * b));
            chk1("fill1_re", mem_re, 1'b1);
            chk1("fill1_stall", cpu_stall, 1'b1);
        end
        @(negedge clk); #1;
        chk1("fill1_done_stall", cpu_stall, 1'b0);
        chk("fill1_rdata", cpu_rdata, 32'hA0);
        chk1("fill1_done_re", mem_re, 1'b0);
        chk("fill1_misses", miss_count, 32'd1);
        chk("fill1_hits_before", hit_count, 32'd0);

        // Same-line hit on 0x4C
        @(negedge clk); cpu_addr = 32'h4C; #1;
        chk("hit1_count", hit_count, 32'd1);
        chk1("hit4c_stall", cpu_stall, 1'b0);
        chk("hit4c_rdata", cpu_rdata, 32'hA3);
        chk1("hit4c_no_re", mem_re, 1'b0);
        @(negedge clk); cpu_re = 1'b0; #1;
        chk("hit2_count", hit_count, 32'd2);

        // Write hit to 0x44 with a slow acknowledge
        cpu_we = 1'b1; cpu_addr = 32'h44; cpu_wdata = 32'hDEADBEEF; mem_ready = 1'b0; #1;
        chk1("wr_idle_stall", cpu_stall, 1'b1);
        chk1("wr_idle_no_we", mem_we, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            chk1("wr_hold_we", mem_we, 1'b1);
            chk("wr_hold_addr", mem_addr, 32'h44);
            chk("wr_hold_data", mem_wdata, 32'hDEADBEEF);
            chk1("wr_hold_stall", cpu_stall, 1'b1);
        end
        @(negedge clk); mem_ready = 1'b1; #1;
        chk1("wr_ack_stall", cpu_stall, 1'b0);
        chk1("wr_ack_we", mem_we, 1'b1);
        @(negedge clk); cpu_we = 1'b0; cpu_re = 1'b1; mem_ready = 1'b0; #1;
        chk("rd_after_wr_data", cpu_rdata, 32'hDEADBEEF);
        chk1("rd_after_wr_stall", cpu_stall, 1'b0);
        chk1("rd_after_wr_no_re", mem_re, 1'b0);
        @(negedge clk); cpu_re = 1'b0; #1;
        chk("hit3_count", hit_count, 32'd3);

        // Write miss to 0x1044: no allocate
        cpu_we = 1'b1; cpu_addr = 32'h1044; cpu_wdata = 32'h12345678; #1;
        chk1("wmiss_stall", cpu_stall, 1'b1);
        @(negedge clk); mem_ready = 1'b1; #1;
        chk1("wmiss_we", mem_we, 1'b1);
        chk("wmiss_addr", mem_addr, 32'h1044);
        chk("wmiss_data", mem_wdata, 32'h12345678);
        chk1("wmiss_ack_stall", cpu_stall, 1'b0);
        @(negedge clk); cpu_we = 1'b0; mem_ready = 1'b0; cpu_re = 1'b1; cpu_addr = 32'h44; #1;
        chk1("noalloc_stall", cpu_stall, 1'b0);
        chk("noalloc_rdata", cpu_rdata, 32'hDEADBEEF);
        chk1("noalloc_no_re", mem_re, 1'b0);
        @(negedge clk); cpu_re = 1'b0; #1;
        chk("hit4_count", hit_count, 32'd4);
        chk("miss1_still", miss_count, 32'd1);

        // Conflict: 0x1040 evicts the tag-0 line
        cpu_re = 1'b1; cpu_addr = 32'h1040; mem_ready = 1'b1; fill_base = 32'hB0; #1;
        chk1("conf_miss_stall", cpu_stall, 1'b1);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk); #1;
            chk("fill2_addr", mem_addr, 32'h1040 + 32'(4 * b));
            chk1("fill2_re", mem_re, 1'b1);
        end
        @(negedge clk); #1;
        chk("fill2_rdata", cpu_rdata, 32'hB0);
        chk1("fill2_done_stall", cpu_stall, 1'b0);
        chk("fill2_misses", miss_count, 32'd2);
        @(negedge clk); cpu_addr = 32'h40; fill_base = 32'hA0; #1;
        chk("hit5_count", hit_count, 32'd5);
        chk1("evicted_miss_stall", cpu_stall, 1'b1);
        chk1("evicted_no_re_yet", mem_re, 1'b0);
        @(negedge clk); #1;
        chk("evicted_misses", miss_count, 32'd3);
        chk("fill3_beat0_addr", mem_addr, 32'h40);
        chk1("fill3_beat0_re", mem_re, 1'b1);

        // Reset during the second fill beat
        @(negedge clk); reset = 1'b0; #1;
        chk1("rst_mid_re", mem_re, 1'b0);
        chk("rst_mid_misses", miss_count, 32'd0);
        chk("rst_mid_hits", hit_count, 32'd0);
        chk1("rst_mid_invalid", cpu_stall, 1'b1);
        @(negedge clk); #1;
        chk1("rst_hold_re", mem_re, 1'b0);
        @(negedge clk); reset = 1'b1; #1;
        chk1("post_rst_stall", cpu_stall, 1'b1);
        chk1("post_rst_no_re", mem_re, 1'b0);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk); #1;
            chk("refill_addr", mem_addr, 32'h40 + 32'(4 * b));
            chk1("refill_re", mem_re, 1'b1);
        end
        @(negedge clk); #1;
        chk("refill_rdata", cpu_rdata, 32'hA0);
        chk1("refill_done_stall", cpu_stall, 1'b0);
        chk("refill_misses", miss_count, 32'd1);
        @(negedge clk); cpu_re = 1'b0; #1;
        chk("refill_hits", hit_count, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
